// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
package pipe_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } seq_state_t;

    localparam int WCNT_W         = 6;
    localparam int MDU_CYCLES_DEF = 32;

    // SPECIAL-opcode funct codes of the instructions that occupy the MDU
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    function automatic logic is_muldiv(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_SPECIAL) &&
               ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
                (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU));
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator between EX and ID
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       lu
);

    logic rs_hit;
    logic rt_hit;

    // $zero is never a real producer, so a load targeting it cannot create a hazard
    assign rs_hit = (ex_rt == id_rs);
    assign rt_hit = id_uses_rt && (ex_rt == id_rt);
    assign lu     = ex_mem_read && (ex_rt != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_sequencer.sv
// rtl/pipe_sequencer.sv - stall/flush sequencer driving PC, IF/ID and ID/EX enables
module pipe_sequencer
    import pipe_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_muldiv,
    input  logic             branch_taken,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_zero,
    output logic             mdu_start,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // The start cycle is the last RUN cycle, so the wait covers MDU_CYCLES-1 cycles
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(MDU_CYCLES - 2);

    seq_state_t        state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              lu;

    load_use_detect u_lu (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .lu          (lu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wcnt         <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        pc_write   = 1'b0;
        IFID_write = 1'b0;
        IFID_flush = 1'b0;
        IDEX_zero  = 1'b1;
        mdu_start  = 1'b0;
        mdu_busy   = 1'b0;

        if (rst) begin
            IFID_flush = 1'b1;
            state_nxt  = RUN;
            wcnt_nxt   = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        pc_write   = 1'b1;
                        IFID_write = 1'b1;
                        IFID_flush = 1'b1;
                    end else if (lu || !imem_ready) begin
                        // hold PC and IF/ID, bubble into EX; re-evaluated next cycle
                    end else if (id_is_muldiv) begin
                        pc_write   = 1'b1;
                        IFID_write = 1'b1;
                        IDEX_zero  = 1'b0;
                        mdu_start  = 1'b1;
                        wcnt_nxt   = WCNT_LOAD;
                        state_nxt  = MDU_WAIT;
                    end else begin
                        pc_write   = 1'b1;
                        IFID_write = 1'b1;
                        IDEX_zero  = 1'b0;
                    end
                end
                MDU_WAIT: begin
                    mdu_busy = 1'b1;
                    if (wcnt == '0)
                        state_nxt = RUN;
                    else
                        wcnt_nxt = wcnt - WCNT_W'(1);
                end
                default: begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb/tb_pipe_sequencer.sv - scoreboard bench for pipe_sequencer against a behavioural model
module tb_pipe_sequencer;

    typedef struct packed {
        logic        pc_write;
        logic        ifid_write;
        logic        ifid_flush;
        logic        idex_zero;
        logic        mdu_start;
        logic        mdu_busy;
        logic [31:0] stall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_mem_read;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       id_uses_rt, id_is_muldiv, branch_taken, imem_ready;

    logic        pw_a, iw_a, if_a, iz_a, ms_a, mb_a;
    logic [31:0] sc_a;
    logic        pw_b, iw_b, if_b, iz_b, ms_b, mb_b;
    logic [2:0]  sc_b;

    always #5 clk = ~clk;

    pipe_sequencer #(.MDU_CYCLES(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_muldiv(id_is_muldiv), .branch_taken(branch_taken), .imem_ready(imem_ready),
        .pc_write(pw_a), .IFID_write(iw_a), .IFID_flush(if_a), .IDEX_zero(iz_a),
        .mdu_start(ms_a), .mdu_busy(mb_a), .stall_cycles(sc_a)
    );

    pipe_sequencer #(.MDU_CYCLES(32), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_muldiv(id_is_muldiv), .branch_taken(branch_taken), .imem_ready(imem_ready),
        .pc_write(pw_b), .IFID_write(iw_b), .IFID_flush(if_b), .IDEX_zero(iz_b),
        .mdu_start(ms_b), .mdu_busy(mb_b), .stall_cycles(sc_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // model state: stall cycles still owed to the MDU, and the saturating stall count
    localparam int      MDU_N [2] = '{4, 32};
    localparam longint  CMAX  [2] = '{64'hFFFF_FFFF, 64'd7};
    int     busy_left [2] = '{0, 0};
    longint cnt       [2] = '{0, 0};

    task automatic drive(input logic r, input logic emr, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic md, input logic br, input logic ir);
        logic hz;
        exp_t e;
        rst = r; ex_mem_read = emr; ex_rt = ert; id_rs = rs; id_rt = rt;
        id_uses_rt = urt; id_is_muldiv = md; branch_taken = br; imem_ready = ir;
        hz = emr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
        for (int i = 0; i < 2; i++) begin
            e = '0;
            e.stall = cnt[i][31:0];
            if (r) begin
                e.ifid_flush = 1; e.idex_zero = 1;
            end else if (busy_left[i] > 0) begin
                e.idex_zero = 1; e.mdu_busy = 1;
            end else if (br) begin
                e.pc_write = 1; e.ifid_write = 1; e.ifid_flush = 1; e.idex_zero = 1;
            end else if (hz || !ir) begin
                e.idex_zero = 1;
            end else if (md) begin
                e.pc_write = 1; e.ifid_write = 1; e.mdu_start = 1;
            end else begin
                e.pc_write = 1; e.ifid_write = 1;
            end
            if (i == 0) q_a.push_back(e); else q_b.push_back(e);
            if (r) begin
                cnt[i] = 0; busy_left[i] = 0;
            end else begin
                if (!e.pc_write && cnt[i] < CMAX[i]) cnt[i] = cnt[i] + 1;
                if (busy_left[i] > 0) busy_left[i] = busy_left[i] - 1;
                else if (e.mdu_start) busy_left[i] = MDU_N[i] - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        exp_t got, want;
        cyc++;
        if (q_a.size() > 0) begin
            want = q_a.pop_front();
            got  = {pw_a, iw_a, if_a, iz_a, ms_a, mb_a, sc_a};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL seq_a cycle=%0d got=%h want=%h", cyc, got, want);
            end
        end
        if (q_b.size() > 0) begin
            want = q_b.pop_front();
            got  = {pw_b, iw_b, if_b, iz_b, ms_b, mb_b, 29'd0, sc_b};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL seq_b cycle=%0d got=%h want=%h", cyc, got, want);
            end
        end
    end

    initial begin
        rst = 1; ex_mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
        id_uses_rt = 0; id_is_muldiv = 1; branch_taken = 0; imem_ready = 1;
        @(posedge clk);
        #1;
        // reset held with a pending muldiv
        drive(1, 0, 0, 0, 0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(2);
        // load-use on rs, then the same with ex_rt=$zero
        drive(0, 1, 5, 5, 0, 0, 0, 0, 1);
        idle(1);
        drive(0, 1, 0, 0, 0, 1, 0, 0, 1);
        // rt-only hazard gated by id_uses_rt
        drive(0, 1, 7, 3, 7, 0, 0, 0, 1);
        drive(0, 1, 7, 3, 7, 1, 0, 0, 1);
        drive(0, 1, 7, 3, 7, 0, 0, 0, 1);
        // single MDU op, then back-to-back muldivs
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(5);
        for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(4);
        // branch beats load-use and muldiv; then load-use with imem wait
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 9, 9, 0, 0, 1, 1, 1);
        drive(0, 1, 9, 9, 0, 0, 0, 0, 0);
        idle(1);
        // reset two cycles into a long MDU wait
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(2);
        // drive the narrow counter past all-ones
        for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 2) == 0,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 4) != 0);
        end
        @(negedge clk);
        #1;
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d want=0/0", q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Central stall/flush sequencer for the 5-stage MIPS pipeline. It arbitrates four competing front-end conditions each cycle and drives the PC, IF/ID and ID/EX control enables: taken-branch flush, load-use hazard, instruction-memory wait, and multi-cycle multiply/divide occupancy. It sits between the hazard comparators and the pipeline registers. It also owns the MDU start handshake and a saturating stall-cycle performance counter.

## Interface
- MDU_CYCLES, 32, total MDU latency in cycles including the start cycle; legal range 2..64
- CNT_W, 32, width of the stall-cycle counter
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of the load in EX
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_is_muldiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- branch_taken  in  1  branch/jump resolved taken in EX this cycle
- imem_ready  in  1  fetch data valid this cycle
- pc_write  out  1  PC load enable
- IFID_write  out  1  IF/ID register load enable
- IFID_flush  out  1  clear IF/ID to a NOP
- IDEX_zero  out  1  zero ID/EX control bits (inject bubble)
- mdu_start  out  1  one-cycle start pulse to MDU
- mdu_busy  out  1  sequencer is in MDU_WAIT
- stall_cycles  out  CNT_W  count of cycles with pc_write low

## Operation
- States: RUN, MDU_WAIT. The count register wcnt is 6 bits wide.
- Load-use hazard (LU) = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- Outputs are Mealy, decoded from the state and the current inputs.
- RUN priority order, highest first:
  1. branch_taken: pc_write=1, IFID_write=1, IFID_flush=1, IDEX_zero=1. No mdu_start. Stay in RUN.
  2. LU: pc_write=0, IFID_write=0, IDEX_zero=1. Stay in RUN.
  3. !imem_ready: pc_write=0, IFID_write=0, IDEX_zero=1. Stay in RUN.
  4. id_is_muldiv: pc_write=1, IFID_write=1, IDEX_zero=0, mdu_start=1. Set wcnt=MDU_CYCLES-2 and go to MDU_WAIT.
  5. Otherwise: pc_write=1, IFID_write=1, IFID_flush=0, IDEX_zero=0.
- MDU_WAIT:
  - pc_write=0, IFID_write=0, IDEX_zero=1, mdu_busy=1.
  - wcnt decrements each cycle; when wcnt==0 the next state is RUN.
  - branch_taken, LU and imem_ready are ignored in this state. EX holds the muldiv instruction or bubbles, so a branch cannot be resolved here.
- stall_cycles increments in every non-reset cycle with pc_write==0. It saturates at all-ones.

## Timing
- While rst is high, outputs are forced to: pc_write=0, IFID_write=0, IFID_flush=1, IDEX_zero=1, mdu_start=0, mdu_busy=0.
- On the first edge with rst high: state=RUN, wcnt=0, stall_cycles=0.
- Reset asserted during MDU_WAIT aborts the wait; the sequencer is in RUN on the cycle after rst deasserts.
- Load-use and imem stalls have zero latency. Each costs one stall per cycle the condition holds, and the condition is re-evaluated every cycle.
- MDU sequence: mdu_start is high in cycle T. MDU_WAIT covers cycles T+1 .. T+MDU_CYCLES-1, which is MDU_CYCLES-1 stall cycles. RUN resumes at T+MDU_CYCLES.
- Back-to-back muldiv: the second one starts in the first RUN cycle after the wait, if no higher-priority condition is present.
- Branch flush lasts one cycle and never starts the MDU, even when id_is_muldiv is set.

## Structure
- The shared package `pipe_pkg` holds:
  - the state enum (RUN, MDU_WAIT)
  - MIPS funct constants for MULT/MULTU/DIV/DIVU, used by the decoder that generates id_is_muldiv
  - the MDU_CYCLES default
- One sub-module, `load_use_detect`: purely combinational, implements the LU equation. Inputs are ex_mem_read, ex_rt, id_rs, id_rt and id_uses_rt; output is lu.
- The FSM, wait counter, output decode and perf counter stay in pipe_sequencer.

## Test plan
- Reset: hold rst for 2 cycles with id_is_muldiv=1. Required: mdu_start=0, IDEX_zero=1, stall_cycles=0, state RUN after release.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for 1 cycle. Required: pc_write=0, IFID_write=0, IDEX_zero=1 that cycle and stall_cycles=1. With ex_rt=0 instead: no stall.
- rt-only hazard: ex_rt=7, id_rt=7, id_rs=3, toggling id_uses_rt. Required: stall only when id_uses_rt=1.
- MDU with MDU_CYCLES=4: id_is_muldiv=1 at T. Required: mdu_start=1 at T only; mdu_busy=1 and pc_write=0 at T+1..T+3; pc_write=1 at T+4; stall_cycles +=3.
- Simultaneous events: branch_taken=1 together with LU=1 and id_is_muldiv=1. Required: IFID_flush=1, pc_write=1, mdu_start=0. Then LU with imem_ready=0: a single stall cycle.
- Reset mid-wait: rst at T+2 during a 32-cycle MDU. Required: mdu_busy=0 the same cycle and RUN afterwards. Separately, preset the counter to all-ones minus 1 and stall 3 cycles: stall_cycles saturates at all-ones.
